// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Purpose:
//   Collects 8 synchronous interrupt lines and latches their rising edges as
//   pending. It applies a per-line mask and a global enable, then picks a
//   winner by fixed priority (bit 0 highest). The winner is presented to the
//   CPU as int_req plus a 16-bit handler vector. In-service state is tracked
//   until the CPU signals int_done.
//
// Configuration:
//   INTC_NESTING_EN - when defined, a strictly higher-priority source may
//                     interrupt a handler that is already in service. When
//                     undefined, only one level is serviced at a time.
//
// Ports:
//   clk        - system clock, all state updates on posedge
//   reset      - synchronous, active-high reset
//   irq_lines  - raw interrupt sources, already synchronous to clk
//   reg_sel    - register select: 0 pending, 1 mask, 2 in_service, 3 control
//   reg_wr     - register write strobe
//   reg_rd     - register read strobe
//   reg_wdata  - register write data
//   reg_rdata  - registered read data, updated one cycle after reg_rd
//   int_req    - interrupt request to the CPU
//   int_vector - handler address, valid while int_req is high
//   int_ack    - CPU accepts the outstanding request
//   int_done   - CPU finished the current handler
// ---------------------------------------------------------------------------
module interrupt_controller #(
    parameter int          SOURCES     = 8,
    parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SOURCES-1:0] irq_lines,
    input  logic [1:0]         reg_sel,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [7:0]         reg_wdata,
    output logic [7:0]         reg_rdata,
    output logic               int_req,
    output logic [15:0]        int_vector,
    input  logic               int_ack,
    input  logic               int_done
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQUEST = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [SOURCES-1:0] ONE = {{(SOURCES-1){1'b0}}, 1'b1};

    // Index of the lowest set bit (highest priority); 0 when the vector is empty.
    function automatic logic [2:0] lowest_idx(input logic [SOURCES-1:0] v);
        lowest_idx = 3'd0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = 3'(i);
        end
    endfunction

    logic [SOURCES-1:0] prev_irq_q;
    logic [SOURCES-1:0] pending_q,    pending_d;
    logic [SOURCES-1:0] mask_q,       mask_d;
    logic [SOURCES-1:0] in_service_q, in_service_d;
    logic               enable_q,     enable_d;
    logic [1:0]         state_q,      state_d;
    logic [2:0]         cur_idx_q,    cur_idx_d;
    logic               int_req_q,    int_req_d;
    logic [15:0]        int_vector_q, int_vector_d;
    logic [7:0]         reg_rdata_q,  reg_rdata_d;

    logic [SOURCES-1:0] edge_w;
    logic [SOURCES-1:0] w1c_w;
    logic [SOURCES-1:0] pending_wr;
    logic [SOURCES-1:0] ack_clr;
    logic [SOURCES-1:0] eligible;
    logic [SOURCES-1:0] isr_pop;
    logic [2:0]         winner;

    assign edge_w   = irq_lines & ~prev_irq_q;
    assign w1c_w    = (reg_wr && reg_sel == 2'd0) ? reg_wdata : '0;
    assign eligible = enable_q ? (pending_q & mask_q) : '0;
    assign winner   = lowest_idx(eligible);

    // A new edge always survives a same-cycle clear (W1C or ack), so the
    // event is never lost.
    for (genvar gi = 0; gi < SOURCES; gi++) begin : g_pending
        assign pending_wr[gi] = (pending_q[gi] & ~w1c_w[gi]) | edge_w[gi];
        assign pending_d[gi]  = (pending_wr[gi] & ~ack_clr[gi]) | edge_w[gi];
    end

    assign mask_d   = (reg_wr && reg_sel == 2'd1) ? reg_wdata : mask_q;
    assign enable_d = (reg_wr && reg_sel == 2'd3) ? reg_wdata[0] : enable_q;

    // int_done retires the highest-priority handler in service; ignored when idle.
    assign isr_pop = (int_done && |in_service_q)
                   ? (in_service_q & ~(ONE << lowest_idx(in_service_q)))
                   : in_service_q;

    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        int_req_d    = int_req_q;
        int_vector_d = int_vector_q;
        in_service_d = isr_pop;
        ack_clr      = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d      = ST_REQUEST;
                    cur_idx_d    = winner;
                    int_req_d    = 1'b1;
                    int_vector_d = VECTOR_BASE + {13'd0, winner};
                end
            end
            ST_REQUEST: begin
                if (int_ack) begin
                    ack_clr      = ONE << cur_idx_q;
                    in_service_d = isr_pop | (ONE << cur_idx_q);
                    int_req_d    = 1'b0;
                    state_d      = ST_SERVICE;
                end else if (!(pending_wr[cur_idx_q] & mask_d[cur_idx_q] & enable_d)) begin
                    // Withdrawal is judged on this cycle's register writes so the
                    // request drops on the very next cycle.
                    int_req_d = 1'b0;
                    state_d   = (|isr_pop) ? ST_SERVICE : ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (isr_pop == '0) begin
                    state_d = ST_IDLE;
                end
`ifdef INTC_NESTING_EN
                else if (|eligible && winner < lowest_idx(isr_pop)) begin
                    state_d      = ST_REQUEST;
                    cur_idx_d    = winner;
                    int_req_d    = 1'b1;
                    int_vector_d = VECTOR_BASE + {13'd0, winner};
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                int_req_d = 1'b0;
            end
        endcase
    end

    // Reads capture the pre-write value of the selected register.
    always_comb begin
        reg_rdata_d = reg_rdata_q;
        if (reg_rd) begin
            case (reg_sel)
                2'd0:    reg_rdata_d = pending_q;
                2'd1:    reg_rdata_d = mask_q;
                2'd2:    reg_rdata_d = in_service_q;
                default: reg_rdata_d = {int_req_q, cur_idx_q, 3'b000, enable_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Lines already high at reset release must not look like edges.
            prev_irq_q   <= irq_lines;
            pending_q    <= '0;
            mask_q       <= '0;
            in_service_q <= '0;
            enable_q     <= 1'b0;
            state_q      <= ST_IDLE;
            cur_idx_q    <= 3'd0;
            int_req_q    <= 1'b0;
            int_vector_q <= VECTOR_BASE;
            reg_rdata_q  <= 8'h00;
        end else begin
            prev_irq_q   <= irq_lines;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            enable_q     <= enable_d;
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            int_req_q    <= int_req_d;
            int_vector_q <= int_vector_d;
            reg_rdata_q  <= reg_rdata_d;
        end
    end

    assign reg_rdata  = reg_rdata_q;
    assign int_req    = int_req_q;
    assign int_vector = int_vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed-vector bench for interrupt_controller. Each comparison goes through
// check(), which prints one line per transaction. Build with INTC_NESTING_EN
// defined to exercise nested service.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_lines;
    logic [1:0]  reg_sel;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        int_req;
    logic [15:0] int_vector;
    logic        int_ack;
    logic        int_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_lines  (irq_lines),
        .reg_sel    (reg_sel),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .int_req    (int_req),
        .int_vector (int_vector),
        .int_ack    (int_ack),
        .int_done   (int_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        reg_sel   = sel;
        reg_wdata = data;
        reg_wr    = 1'b1;
        tick();
        reg_wr    = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        reg_sel = sel;
        reg_rd  = 1'b1;
        tick();
        reg_rd  = 1'b0;
        check(tag, {24'd0, reg_rdata}, {24'd0, exp});
    endtask

    task automatic pulse_irq(input logic [7:0] lines);
        irq_lines = lines;
        tick();
        irq_lines = 8'h00;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        irq_lines = 8'hFF;
        reg_sel   = 2'd0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_wdata = 8'h00;
        int_ack   = 1'b0;
        int_done  = 1'b0;

        // Reset with all lines held high
        repeat (3) tick();
        check("rst_int_req", {31'd0, int_req}, 32'd0);
        check("rst_vector", {16'd0, int_vector}, 32'h0010);
        check("rst_rdata", {24'd0, reg_rdata}, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        rdchk("rst_release_pending", 2'd0, 8'h00);
        rdchk("rst_ctrl", 2'd3, 8'h00);
        irq_lines = 8'h00;
        tick();

        // Single source on line 0
        wr(2'd1, 8'h01);
        wr(2'd3, 8'h01);
        pulse_irq(8'h01);
        check("lat_n1_no_req", {31'd0, int_req}, 32'd0);
        tick();
        check("lat_n2_req", {31'd0, int_req}, 32'd1);
        check("vec_line0", {16'd0, int_vector}, 32'h0010);
        rdchk("ctrl_req0", 2'd3, 8'h81);
        ack();
        check("ack_drops_req", {31'd0, int_req}, 32'd0);
        rdchk("ack_pending", 2'd0, 8'h00);
        rdchk("ack_isr", 2'd2, 8'h01);
        done();
        rdchk("done_isr", 2'd2, 8'h00);
        rdchk("done_ctrl", 2'd3, 8'h01);

        // Simultaneous edges on lines 5 and 2
        wr(2'd1, 8'hFF);
        pulse_irq(8'h24);
        tick();
        check("prio_req", {31'd0, int_req}, 32'd1);
        check("prio_vec2", {16'd0, int_vector}, 32'h0012);
        rdchk("prio_ctrl", 2'd3, 8'hA1);
        ack();
        done();
        tick();
        check("prio_req5", {31'd0, int_req}, 32'd1);
        check("prio_vec5", {16'd0, int_vector}, 32'h0015);
        ack();
        done();
        rdchk("prio_pending_empty", 2'd0, 8'h00);

        // Withdrawal by masking, then by W1C
        wr(2'd1, 8'h08);
        pulse_irq(8'h08);
        tick();
        check("wd_req", {31'd0, int_req}, 32'd1);
        check("wd_vec3", {16'd0, int_vector}, 32'h0013);
        wr(2'd1, 8'h00);
        check("wd_mask_drop", {31'd0, int_req}, 32'd0);
        rdchk("wd_pending_kept", 2'd0, 8'h08);
        rdchk("wd_ctrl", 2'd3, 8'h31);
        wr(2'd1, 8'h08);
        tick();
        check("wd_rearm_req", {31'd0, int_req}, 32'd1);
        wr(2'd0, 8'h08);
        check("wd_w1c_drop", {31'd0, int_req}, 32'd0);
        rdchk("wd_w1c_pending", 2'd0, 8'h00);

        // W1C colliding with a new edge on the same line
        pulse_irq(8'h04);
        tick();
        irq_lines = 8'h04;
        reg_sel   = 2'd0;
        reg_wdata = 8'h04;
        reg_wr    = 1'b1;
        tick();
        reg_wr    = 1'b0;
        irq_lines = 8'h00;
        rdchk("w1c_collision", 2'd0, 8'h04);
        wr(2'd0, 8'h04);
        rdchk("w1c_plain", 2'd0, 8'h00);

        // Read and write of the same register in one cycle returns old value
        reg_sel   = 2'd1;
        reg_wdata = 8'h55;
        reg_rd    = 1'b1;
        reg_wr    = 1'b1;
        tick();
        reg_rd    = 1'b0;
        reg_wr    = 1'b0;
        check("rdwr_old", {24'd0, reg_rdata}, 32'h08);
        rdchk("rdwr_new", 2'd1, 8'h55);
        wr(2'd2, 8'hFF);
        rdchk("isr_ro", 2'd2, 8'h00);

        // Higher-priority arrival while servicing line 4
        wr(2'd1, 8'hFF);
        pulse_irq(8'h10);
        tick();
        check("nest_vec4", {16'd0, int_vector}, 32'h0014);
        ack();
        rdchk("nest_isr4", 2'd2, 8'h10);
        pulse_irq(8'h02);
        tick();
`ifdef INTC_NESTING_EN
        check("nest_req1", {31'd0, int_req}, 32'd1);
        check("nest_vec1", {16'd0, int_vector}, 32'h0011);
        ack();
        rdchk("nest_isr12", 2'd2, 8'h12);
        done();
        rdchk("nest_pop1", 2'd2, 8'h10);
        check("nest_no_req", {31'd0, int_req}, 32'd0);
        done();
        rdchk("nest_pop4", 2'd2, 8'h00);
        check("nest_idle", {31'd0, int_req}, 32'd0);
`else
        check("single_wait", {31'd0, int_req}, 32'd0);
        done();
        tick();
        check("single_req1", {31'd0, int_req}, 32'd1);
        check("single_vec1", {16'd0, int_vector}, 32'h0011);
        ack();
        rdchk("single_isr1", 2'd2, 8'h02);
        done();
        rdchk("single_isr0", 2'd2, 8'h00);
`endif

        // Reset during SERVICE
        pulse_irq(8'h01);
        tick();
        check("svc_req", {31'd0, int_req}, 32'd1);
        ack();
        rdchk("svc_isr", 2'd2, 8'h01);
        reset = 1'b1;
        tick();
        check("svc_rst_req", {31'd0, int_req}, 32'd0);
        check("svc_rst_rdata", {24'd0, reg_rdata}, 32'd0);
        check("svc_rst_vec", {16'd0, int_vector}, 32'h0010);
        reset = 1'b0;
        tick();
        rdchk("svc_rst_isr", 2'd2, 8'h00);
        rdchk("svc_rst_mask", 2'd1, 8'h00);
        rdchk("svc_rst_ctrl", 2'd3, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
